deserializer_arbiter: RTL
=========================

# deserializer_arbiter

Sequencing controller that shares one 14-bit serial deserializer between two serial requesters. It grants the deserializer round-robin and drives its select, data and acknowledge lines. It captures each completed 14-bit word into a one-entry output register with valid/ready handshake and source tag. It sits between the switch/LED-level serial sources and the deserializer FSM; the state is exported for LED debug.

## Interface
Parameters:
- WORD_W, 14, deserialized word width
- TIMEOUT, 63, max cycles in SHIFT or ACK before abort (6-bit counter)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  2  requester i wants to send one frame; held high for the whole frame
- ser_in  in  2  serial data bit of requester i
- gnt  out  2  one-hot grant; 0 when idle
- des_ss  out  1  deserializer select/start; high only in SHIFT
- des_data  out  1  ser_in[granted index] in SHIFT, else 0 (combinational mux)
- des_ready  in  1  deserializer has a full word; held until acknowledged
- des_word  in  WORD_W  deserializer parallel output
- des_ack  out  1  acknowledge to deserializer; high only in ACK
- word_valid  out  1  output register holds a word
- word_ready  in  1  consumer accepts word
- word_data  out  WORD_W  captured word
- word_src  out  1  index of requester that produced word_data
- timeout_err  out  1  one-cycle pulse on SHIFT/ACK timeout
- state_q  out  2  current state encoding, for LEDs

## Operation
- States: IDLE=0, SHIFT=1, ACK=2.
- IDLE: if req!=0 and word_valid==0, grant via round-robin, go SHIFT. Else stay.
- Round-robin: pointer last holds last granted index (reset 1, so requester 0 wins first contention). Single request: granted. Both: grant !last. last updates on grant.
- SHIFT: gnt/des_ss asserted, des_data = ser_in[idx].
  - des_ready==1: capture des_word to word_data, idx to word_src, set word_valid; go ACK.
  - Else req[idx]==0: abort, go IDLE, no word, no error.
  - Else counter==TIMEOUT: timeout_err pulse, go IDLE.
- ACK: des_ack=1, gnt held. des_ready==0: go IDLE. counter==TIMEOUT: timeout_err, go IDLE.
- Priority in one cycle: des_ready > req drop > timeout.
- Counter: cleared on every state entry, increments each cycle in SHIFT/ACK, saturates at TIMEOUT.
- Output register: word_valid clears the cycle after valid&&word_ready. No new grant while word_valid==1. A capture therefore never overwrites.
- Reset values: state IDLE, gnt 0, des_ss 0, des_ack 0, word_valid 0, word_data 0, word_src 0, timeout_err 0, counter 0, last 1. des_data 0.
- Reset mid-frame: immediate return to IDLE, partial word discarded.

## Timing
- All outputs registered except des_data (mux of ser_in).
- req seen in IDLE at edge N: state=SHIFT, gnt and des_ss high after edge N.
- des_ready high in SHIFT at edge M: word_valid, word_data and des_ack high after edge M.
- des_ready low in ACK at edge K: IDLE after K. The earliest next grant is edge K+1, if the output register is empty.
- A word accepted at edge K allows a grant at edge K+1; there is no same-cycle bypass.
- timeout_err is high for exactly the cycle after the timeout edge.

## Structure
- Package deser_ctrl_pkg: state enum (IDLE/SHIFT/ACK, 2-bit), WORD_W, TIMEOUT defaults.
- Sub-module rr_arbiter2: inputs req[1:0], last, enable; outputs one-hot grant and index. It is purely combinational; the last register stays in the parent.
- Parent holds the FSM, counter, output register and muxes.

## Test plan
- Single frame: req=01, model deserializer raises des_ready with des_word=14'h2A5C after 14 cycles. Required: word_valid=1, word_data=14'h2A5C, word_src=0, des_ack high until des_ready drops, then IDLE.
- Contention: req=11 held, consumer always ready, three frames. Required: grants go 0,1,0 and word_src sequence is 0,1,0.
- Backpressure: word_ready=0 after the first capture with req=10 still held. Required: gnt stays 0 and word_data is stable. Raise word_ready: transfer, then grant 1 on the following cycle.
- Timeout: des_ready never rises. Required: timeout_err pulses exactly once, 64 cycles into SHIFT; state returns to IDLE; word_valid stays 0.
- Abort: drop req[0] at SHIFT cycle 5. Required: IDLE next cycle, no word, no timeout_err. Also drop req[0] in the same cycle as des_ready: word is captured.
- Async reset asserted mid-SHIFT, not aligned to clock. Required: all outputs take reset values immediately; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/deser_ctrl_pkg.sv
// deser_ctrl_pkg: shared state encoding and default sizing for the deserializer sequencer
package deser_ctrl_pkg;
  localparam int DEF_WORD_W = 14;
  localparam int DEF_TIMEOUT = 63;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, ACK = 2'd2} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick, purely combinational
//   req    requests from the two serial sources
//   last   index granted most recently (register lives in the parent)
//   enable allow a grant this cycle
//   grant  one-hot grant, zero when disabled or nothing requested
//   idx    index that wins if a grant is issued
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       idx
);
  always_comb begin
    idx = (req == 2'b11) ? ~last : req[1];
    grant = (enable && |req) ? (idx ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/deserializer_arbiter.sv
// deserializer_arbiter: shares one serial deserializer between two requesters
//   clock/reset            system clock, async active-high reset
//   req, ser_in            per-requester frame request and serial bit
//   gnt, des_ss, des_data  grant, deserializer select and muxed serial bit
//   des_ready, des_word    deserializer word-complete flag and parallel word
//   des_ack                acknowledge back to the deserializer
//   word_valid/ready/data/src  one-entry output register with source tag
//   timeout_err            one-cycle pulse when SHIFT or ACK stalls too long
//   state_q                current state, for debug LEDs
module deserializer_arbiter
  import deser_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        ser_in,
  output logic [1:0]        gnt,
  output logic              des_ss,
  output logic              des_data,
  input  logic              des_ready,
  input  logic [WORD_W-1:0] des_word,
  output logic              des_ack,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_src,
  output logic              timeout_err,
  output logic [1:0]        state_q
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             idx;
  logic             arb_idx;
  logic [1:0]       arb_gnt;
  logic             cnt_max;
  assign idx = gnt[1];
  assign cnt_max = cnt == CNT_W'(TIMEOUT);
  assign state_q = state;
  assign des_data = (state == SHIFT) && ser_in[idx];
  // A full output register blocks new grants, so a capture never overwrites.
  rr_arbiter2 u_arb (
    .req   (req),
    .last  (last),
    .enable((state == IDLE) && !word_valid),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      des_ss      <= 1'b0;
      des_ack     <= 1'b0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_src    <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      last        <= 1'b1;
    end else begin
      timeout_err <= 1'b0;
      cnt <= (state == IDLE || cnt_max) ? cnt : cnt + 1'b1;
      if (word_valid && word_ready) word_valid <= 1'b0;
      case (state)
        IDLE:
          if (|arb_gnt) begin
            state  <= SHIFT;
            gnt    <= arb_gnt;
            des_ss <= 1'b1;
            last   <= arb_idx;
            cnt    <= '0;
          end
        SHIFT:
          if (des_ready) begin
            state      <= ACK;
            des_ss     <= 1'b0;
            des_ack    <= 1'b1;
            word_valid <= 1'b1;
            word_data  <= des_word;
            word_src   <= idx;
            cnt        <= '0;
          end else if (!req[idx] || cnt_max) begin
            // A dropped request is a clean abort; only a stall flags an error.
            state       <= IDLE;
            gnt         <= '0;
            des_ss      <= 1'b0;
            cnt         <= '0;
            timeout_err <= req[idx];
          end
        ACK:
          if (!des_ready || cnt_max) begin
            state       <= IDLE;
            gnt         <= '0;
            des_ack     <= 1'b0;
            cnt         <= '0;
            timeout_err <= des_ready;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
